// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-N stream demultiplexer.
package demux_pkg;

   typedef enum logic [1:0] {
      MODE_DIRECTED  = 2'b00,
      MODE_BROADCAST = 2'b01,
      MODE_RR        = 2'b10,
      MODE_RESERVED  = 2'b11
   } mode_e;

   localparam int CNT_W = 16;

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: holds a word until its consumer takes it.
module demux_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             drain,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             free
);

   logic             valid_d, valid_q;
   logic [WIDTH-1:0] data_d, data_q;

   // A load wins over a drain, so draining and refilling in one cycle keeps the slot full.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (valid_q && drain) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;
   assign free  = ~valid_q | drain;

endmodule

// File: rtl/demux1xn_stream.sv
// Registered 1-to-N stream demultiplexer with directed, broadcast and round-robin routing.
module demux1xn_stream
   import demux_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int N     = 8,
   localparam int SELW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SELW-1:0]    sel,
   input  logic [1:0]         mode,
   output logic [N*WIDTH-1:0] out_data,
   output logic [N-1:0]       out_valid,
   input  logic [N-1:0]       out_ready,
   output logic               sel_err,
   output logic [CNT_W-1:0]   accept_cnt
);

   localparam logic [SELW-1:0] RR_LAST = SELW'(N - 1);

   mode_e            mode_s;
   logic             sel_ok;
   logic             is_directed;
   logic             accept;
   logic [N-1:0]     target;
   logic [N-1:0]     slot_free;
   logic [N-1:0]     slot_load;
   logic [SELW-1:0]  rr_ptr_d, rr_ptr_q;
   logic             sel_err_d, sel_err_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   assign mode_s = mode_e'(mode);

   // Only a non-power-of-two channel count leaves select codes with no channel behind them.
   if (N == (1 << SELW)) begin : g_sel_full
      assign sel_ok = 1'b1;
   end else begin : g_sel_partial
      localparam logic [SELW:0] N_LIM = (SELW + 1)'(N);
      assign sel_ok = ({1'b0, sel} < N_LIM);
   end

   always_comb begin
      target      = '0;
      is_directed = 1'b0;
      case (mode_s)
         MODE_BROADCAST: target = '1;
         MODE_RR:        target[rr_ptr_q] = 1'b1;
         default: begin
            is_directed = 1'b1;
            if (sel_ok) target[sel] = 1'b1;
         end
      endcase
   end

   // An empty target set (dropped word) reduces to ready, so no special case is needed.
   assign in_ready  = &(slot_free | ~target);
   assign accept    = in_valid & in_ready;
   assign slot_load = target & {N{accept}};

   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      sel_err_d = accept & is_directed & ~sel_ok;
      cnt_d     = cnt_q;
      if (accept) begin
         cnt_d = cnt_q + 1'b1;
         if (mode_s == MODE_RR) begin
            rr_ptr_d = (rr_ptr_q == RR_LAST) ? '0 : rr_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q  <= '0;
         sel_err_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         sel_err_q <= sel_err_d;
         cnt_q     <= cnt_d;
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_slot
      demux_slot #(
         .WIDTH(WIDTH)
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .load      (slot_load[k]),
         .load_data (in_data),
         .drain     (out_ready[k]),
         .valid     (out_valid[k]),
         .data      (out_data[k*WIDTH +: WIDTH]),
         .free      (slot_free[k])
      );
   end

   assign sel_err    = sel_err_q;
   assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_demux1xn_stream.sv
// Directed self-checking bench for demux1xn_stream (N=8 and N=6 instances).
module tb_demux1xn_stream;

   logic        clk;
   logic        rst;

   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  sel;
   logic [1:0]  mode;
   logic [63:0] out_data;
   logic [7:0]  out_valid;
   logic [7:0]  out_ready;
   logic        sel_err;
   logic [15:0] accept_cnt;

   logic [7:0]  in_data6;
   logic        in_valid6;
   logic        in_ready6;
   logic [2:0]  sel6;
   logic [1:0]  mode6;
   logic [47:0] out_data6;
   logic [5:0]  out_valid6;
   logic [5:0]  out_ready6;
   logic        sel_err6;
   logic [15:0] accept_cnt6;

   int n_cmp;
   int n_bad;

   demux1xn_stream #(.WIDTH(8), .N(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sel        (sel),
      .mode       (mode),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sel_err    (sel_err),
      .accept_cnt (accept_cnt)
   );

   demux1xn_stream #(.WIDTH(8), .N(6)) dut6 (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data6),
      .in_valid   (in_valid6),
      .in_ready   (in_ready6),
      .sel        (sel6),
      .mode       (mode6),
      .out_data   (out_data6),
      .out_valid  (out_valid6),
      .out_ready  (out_ready6),
      .sel_err    (sel_err6),
      .accept_cnt (accept_cnt6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_data = '0; in_valid = 1'b0; sel = '0; mode = 2'b00; out_ready = '1;
      in_data6 = '0; in_valid6 = 1'b0; sel6 = '0; mode6 = 2'b00; out_ready6 = '1;
      tick();
      tick();
      n_cmp++; if (out_valid !== 8'h00) begin n_bad++; $display("[TB] FAIL rst_valid: got %h expected %h", out_valid, 8'h00); end
      n_cmp++; if (out_data !== 64'h0) begin n_bad++; $display("[TB] FAIL rst_data: got %h expected %h", out_data, 64'h0); end
      n_cmp++; if (sel_err !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_sel_err: got %b expected %b", sel_err, 1'b0); end
      n_cmp++; if (accept_cnt !== 16'd0) begin n_bad++; $display("[TB] FAIL rst_cnt: got %0d expected %0d", accept_cnt, 0); end
      n_cmp++; if (out_valid6 !== 6'h00) begin n_bad++; $display("[TB] FAIL rst_valid6: got %h expected %h", out_valid6, 6'h00); end
      n_cmp++; if (accept_cnt6 !== 16'd0) begin n_bad++; $display("[TB] FAIL rst_cnt6: got %0d expected %0d", accept_cnt6, 0); end
      #2 rst = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      mode = 2'b00; sel = 3'd3; in_data = 8'hA5; out_ready = 8'hFF; in_valid = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL dir_ready: got %b expected %b", in_ready, 1'b1); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 8'h08) begin n_bad++; $display("[TB] FAIL dir_valid: got %h expected %h", out_valid, 8'h08); end
      n_cmp++; if (out_data[31:24] !== 8'hA5) begin n_bad++; $display("[TB] FAIL dir_data: got %h expected %h", out_data[31:24], 8'hA5); end
      n_cmp++; if (accept_cnt !== 16'd1) begin n_bad++; $display("[TB] FAIL dir_cnt: got %0d expected %0d", accept_cnt, 1); end
      tick();
      n_cmp++; if (out_valid !== 8'h00) begin n_bad++; $display("[TB] FAIL dir_drain: got %h expected %h", out_valid, 8'h00); end
      n_cmp++; if (out_data[31:24] !== 8'hA5) begin n_bad++; $display("[TB] FAIL dir_hold: got %h expected %h", out_data[31:24], 8'hA5); end
   endtask

   task automatic test_broadcast();
      mode = 2'b00; sel = 3'd5; in_data = 8'h11; out_ready = 8'hDF; in_valid = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 8'h20) begin n_bad++; $display("[TB] FAIL bc_fill: got %h expected %h", out_valid, 8'h20); end
      mode = 2'b01; in_data = 8'h3C;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL bc_stall_ready: got %b expected %b", in_ready, 1'b0); end
      tick();
      n_cmp++; if (out_valid !== 8'h20) begin n_bad++; $display("[TB] FAIL bc_stall_valid: got %h expected %h", out_valid, 8'h20); end
      n_cmp++; if (out_data[47:40] !== 8'h11) begin n_bad++; $display("[TB] FAIL bc_stall_data: got %h expected %h", out_data[47:40], 8'h11); end
      n_cmp++; if (accept_cnt !== 16'd2) begin n_bad++; $display("[TB] FAIL bc_stall_cnt: got %0d expected %0d", accept_cnt, 2); end
      out_ready = 8'hFF;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL bc_release_ready: got %b expected %b", in_ready, 1'b1); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 8'hFF) begin n_bad++; $display("[TB] FAIL bc_valid: got %h expected %h", out_valid, 8'hFF); end
      n_cmp++; if (out_data !== 64'h3C3C_3C3C_3C3C_3C3C) begin n_bad++; $display("[TB] FAIL bc_data: got %h expected %h", out_data, 64'h3C3C_3C3C_3C3C_3C3C); end
      n_cmp++; if (accept_cnt !== 16'd3) begin n_bad++; $display("[TB] FAIL bc_cnt: got %0d expected %0d", accept_cnt, 3); end
      tick();
      n_cmp++; if (out_valid !== 8'h00) begin n_bad++; $display("[TB] FAIL bc_drain: got %h expected %h", out_valid, 8'h00); end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_v;
      int ch;
      mode = 2'b10; out_ready = 8'hFF; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 8'(i);
         tick();
         ch = i % 8;
         exp_v = 8'h01 << ch;
         n_cmp++; if (out_valid !== exp_v) begin n_bad++; $display("[TB] FAIL rr_valid[%0d]: got %h expected %h", i, out_valid, exp_v); end
         n_cmp++; if (out_data[ch*8 +: 8] !== 8'(i)) begin n_bad++; $display("[TB] FAIL rr_data[%0d]: got %h expected %h", i, out_data[ch*8 +: 8], 8'(i)); end
      end
      in_valid = 1'b0;
      n_cmp++; if (accept_cnt !== 16'd13) begin n_bad++; $display("[TB] FAIL rr_cnt: got %0d expected %0d", accept_cnt, 13); end
      mode = 2'b00;
      tick();
      mode = 2'b10; in_data = 8'h77; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 8'h04) begin n_bad++; $display("[TB] FAIL rr_ptr2: got %h expected %h", out_valid, 8'h04); end
      n_cmp++; if (out_data[23:16] !== 8'h77) begin n_bad++; $display("[TB] FAIL rr_ptr2_data: got %h expected %h", out_data[23:16], 8'h77); end
      tick();
   endtask

   task automatic test_back_to_back();
      mode = 2'b00; sel = 3'd2; out_ready = 8'hFB; in_data = 8'h21; in_valid = 1'b1;
      tick();
      in_data = 8'h22;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_stall_ready: got %b expected %b", in_ready, 1'b0); end
      tick();
      n_cmp++; if (out_valid !== 8'h04) begin n_bad++; $display("[TB] FAIL b2b_stall_valid: got %h expected %h", out_valid, 8'h04); end
      n_cmp++; if (out_data[23:16] !== 8'h21) begin n_bad++; $display("[TB] FAIL b2b_stall_data: got %h expected %h", out_data[23:16], 8'h21); end
      out_ready = 8'hFF;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_release_ready: got %b expected %b", in_ready, 1'b1); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 8'h04) begin n_bad++; $display("[TB] FAIL b2b_refill_valid: got %h expected %h", out_valid, 8'h04); end
      n_cmp++; if (out_data[23:16] !== 8'h22) begin n_bad++; $display("[TB] FAIL b2b_refill_data: got %h expected %h", out_data[23:16], 8'h22); end
      n_cmp++; if (accept_cnt !== 16'd16) begin n_bad++; $display("[TB] FAIL b2b_cnt: got %0d expected %0d", accept_cnt, 16); end
      tick();
      n_cmp++; if (out_valid !== 8'h00) begin n_bad++; $display("[TB] FAIL b2b_drain: got %h expected %h", out_valid, 8'h00); end
   endtask

   task automatic test_sel_err();
      mode6 = 2'b00; sel6 = 3'd7; in_data6 = 8'h5A; out_ready6 = 6'h3F; in_valid6 = 1'b1;
      #1;
      n_cmp++; if (in_ready6 !== 1'b1) begin n_bad++; $display("[TB] FAIL serr_ready: got %b expected %b", in_ready6, 1'b1); end
      tick();
      in_valid6 = 1'b0;
      n_cmp++; if (sel_err6 !== 1'b1) begin n_bad++; $display("[TB] FAIL serr_pulse: got %b expected %b", sel_err6, 1'b1); end
      n_cmp++; if (out_valid6 !== 6'h00) begin n_bad++; $display("[TB] FAIL serr_valid: got %h expected %h", out_valid6, 6'h00); end
      n_cmp++; if (accept_cnt6 !== 16'd1) begin n_bad++; $display("[TB] FAIL serr_cnt: got %0d expected %0d", accept_cnt6, 1); end
      tick();
      n_cmp++; if (sel_err6 !== 1'b0) begin n_bad++; $display("[TB] FAIL serr_clear: got %b expected %b", sel_err6, 1'b0); end
      sel6 = 3'd5; in_data6 = 8'hC3; in_valid6 = 1'b1;
      tick();
      in_valid6 = 1'b0;
      n_cmp++; if (out_valid6 !== 6'h20) begin n_bad++; $display("[TB] FAIL serr_top_valid: got %h expected %h", out_valid6, 6'h20); end
      n_cmp++; if (out_data6[47:40] !== 8'hC3) begin n_bad++; $display("[TB] FAIL serr_top_data: got %h expected %h", out_data6[47:40], 8'hC3); end
      n_cmp++; if (sel_err6 !== 1'b0) begin n_bad++; $display("[TB] FAIL serr_top_noerr: got %b expected %b", sel_err6, 1'b0); end
      n_cmp++; if (accept_cnt6 !== 16'd2) begin n_bad++; $display("[TB] FAIL serr_top_cnt: got %0d expected %0d", accept_cnt6, 2); end
   endtask

   task automatic test_async_reset();
      out_ready = 8'h00;
      mode = 2'b10; in_data = 8'hE3; in_valid = 1'b1;
      tick();
      mode = 2'b00; sel = 3'd0; in_data = 8'hE0;
      tick();
      sel = 3'd1; in_data = 8'hE1;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 8'h0B) begin n_bad++; $display("[TB] FAIL ar_prefill: got %h expected %h", out_valid, 8'h0B); end
      #3 rst = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 8'h00) begin n_bad++; $display("[TB] FAIL ar_valid: got %h expected %h", out_valid, 8'h00); end
      n_cmp++; if (out_data !== 64'h0) begin n_bad++; $display("[TB] FAIL ar_data: got %h expected %h", out_data, 64'h0); end
      n_cmp++; if (accept_cnt !== 16'd0) begin n_bad++; $display("[TB] FAIL ar_cnt: got %0d expected %0d", accept_cnt, 0); end
      #1 rst = 1'b0;
      tick();
      out_ready = 8'hFF; mode = 2'b10; in_data = 8'h99; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 8'h01) begin n_bad++; $display("[TB] FAIL ar_rr_ptr: got %h expected %h", out_valid, 8'h01); end
      n_cmp++; if (accept_cnt !== 16'd1) begin n_bad++; $display("[TB] FAIL ar_cnt_after: got %0d expected %0d", accept_cnt, 1); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_directed();
      test_broadcast();
      test_round_robin();
      test_back_to_back();
      test_sel_err();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
